// File: rtl/pc_update_unit.sv
// -----------------------------------------------------------------------------
// pc_update_unit
//
// Purpose:
//   Program-counter sequencer for a single-issue fetch stage. After reset
//   it spends one cycle in INIT, then fetches sequentially in RUN. It follows
//   JALR / JAL / conditional-branch redirects, counting each one that
//   commits. A misaligned non-sequential target parks the unit in TRAP. TRAP
//   holds the faulting pc and raises a sticky misalign_trap flag, and only
//   reset leaves it.
//
// Ports:
//   clk           in   rising-edge clock
//   reset_n       in   asynchronous active-low reset
//   Btaken        in   conditional branch taken
//   Jump          in   JAL instruction
//   Jalr          in   JALR instruction
//   imm[31:0]     in   sign-extended immediate
//   rs1_data[31:0] in  register rs1 value (JALR base)
//   imem_ready    in   instruction at pc returned this cycle
//   pc[31:0]      out  current fetch address
//   pc_plus4[31:0] out pc + 4 (link value)
//   fetch_req     out  instruction request at pc (RUN only)
//   redirect      out  non-sequential update commits on the next edge
//   misalign_trap out  sticky misaligned-target fault
//   taken_cnt     out  saturating count of committed redirects
// -----------------------------------------------------------------------------
module pc_update_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             Btaken,
   input  logic             Jump,
   input  logic             Jalr,
   input  logic [31:0]      imm,
   input  logic [31:0]      rs1_data,
   input  logic             imem_ready,
   output logic [31:0]      pc,
   output logic [31:0]      pc_plus4,
   output logic             fetch_req,
   output logic             redirect,
   output logic             misalign_trap,
   output logic [CNT_W-1:0] taken_cnt
);

   localparam logic [1:0] S_INIT = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_TRAP = 2'b10;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       r_state;
   logic [31:0]      r_pc;
   logic             r_trap;
   logic [CNT_W-1:0] r_cnt;

   logic [31:0]      w_pc_plus4;
   logic [31:0]      w_target;
   logic             w_nonseq;
   logic             w_misalign;
   logic             w_advance;
   logic             w_redirect;
   logic             w_cnt_full;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_nonseq   = Jalr | Jump | Btaken;

   // Priority Jalr > Jump/Btaken > sequential. Jump and Btaken share one
   // pc-relative adder, so asserting both behaves as a single redirect.
   always_comb begin
      // NOTE: default assignment first so no path through the block leaves
      // w_target unassigned, which would infer a latch.
      w_target = w_pc_plus4;
      if (Jalr)
         w_target = (rs1_data + imm) & 32'hFFFF_FFFE;
      else if (Jump || Btaken)
         w_target = r_pc + imm;
   end

   // The sequential path is always word-aligned, so only a selected
   // non-sequential target can fault.
   assign w_misalign = w_nonseq && (w_target[1:0] != 2'b00);
   assign w_advance  = (r_state == S_RUN) && imem_ready;
   assign w_redirect = w_advance && w_nonseq && !w_misalign;
   assign w_cnt_full = &r_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_INIT;
         r_pc    <= RESET_PC;
         r_trap  <= 1'b0;
         r_cnt   <= '0;
      end else begin
         case (r_state)
            S_INIT: r_state <= S_RUN;
            S_RUN: begin
               if (imem_ready) begin
                  if (w_misalign) begin
                     // pc keeps the faulting instruction address.
                     r_state <= S_TRAP;
                     r_trap  <= 1'b1;
                  end else begin
                     r_pc <= w_target;
                     if (w_redirect && !w_cnt_full)
                        r_cnt <= r_cnt + CNT_ONE;
                  end
               end
            end
            S_TRAP: r_state <= S_TRAP;
            // The unused encoding is treated as a fault: park until reset.
            default: begin
               r_state <= S_TRAP;
               r_trap  <= 1'b1;
            end
         endcase
      end
   end

   assign pc            = r_pc;
   assign pc_plus4      = w_pc_plus4;
   assign fetch_req     = (r_state == S_RUN);
   assign redirect      = w_redirect;
   assign misalign_trap = r_trap;
   assign taken_cnt     = r_cnt;

endmodule

// File: tb/tb_pc_update_unit.sv
// -----------------------------------------------------------------------------
// tb_pc_update_unit
//
// Self-checking bench for pc_update_unit (built with CNT_W=4 so the
// saturation boundary is reachable). A behavioural model tracks the
// architectural PC, counter and trap flag. One compare process checks every
// output against it each cycle. Directed sequences with hand-computed
// literals are followed by a randomized run with occasional asynchronous
// resets.
// -----------------------------------------------------------------------------
module tb_pc_update_unit;

   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n = 1'b1;
   logic             Btaken = 1'b0;
   logic             Jump = 1'b0;
   logic             Jalr = 1'b0;
   logic [31:0]      imm = '0;
   logic [31:0]      rs1_data = '0;
   logic             imem_ready = 1'b0;
   logic [31:0]      pc;
   logic [31:0]      pc_plus4;
   logic             fetch_req;
   logic             redirect;
   logic             misalign_trap;
   logic [CNT_W-1:0] taken_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pc_update_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .Btaken        (Btaken),
      .Jump          (Jump),
      .Jalr          (Jalr),
      .imm           (imm),
      .rs1_data      (rs1_data),
      .imem_ready    (imem_ready),
      .pc            (pc),
      .pc_plus4      (pc_plus4),
      .fetch_req     (fetch_req),
      .redirect      (redirect),
      .misalign_trap (misalign_trap),
      .taken_cnt     (taken_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_started: the single post-reset idle cycle has elapsed.
   bit          m_started = 1'b0;
   bit          m_trapped = 1'b0;
   logic [31:0] m_pc      = 32'h0;
   int          m_cnt     = 0;

   function automatic logic [31:0] model_target();
      logic [31:0] t;
      if (Jalr)               t = (rs1_data + imm) & 32'hFFFF_FFFE;
      else if (Jump || Btaken) t = m_pc + imm;
      else                    t = m_pc + 32'd4;
      return t;
   endfunction

   function automatic bit model_running();
      return reset_n && m_started && !m_trapped;
   endfunction

   function automatic bit model_redirect();
      logic [31:0] t;
      t = model_target();
      return model_running() && imem_ready && (Jalr || Jump || Btaken) && (t[1:0] == 2'b00);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_started = 1'b0;
         m_trapped = 1'b0;
         m_pc      = 32'h0;
         m_cnt     = 0;
      end else if (!m_started) begin
         m_started = 1'b1;
      end else if (!m_trapped && imem_ready) begin
         logic [31:0] t;
         t = model_target();
         if ((Jalr || Jump || Btaken) && t[1:0] != 2'b00) begin
            m_trapped = 1'b1;
         end else begin
            if (Jalr || Jump || Btaken) m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            m_pc = t;
         end
      end
   end

   // Single compare process: mid-cycle, inputs and outputs stable.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         check("cmp_pc",        pc,                      m_pc);
         check("cmp_pc_plus4",  pc_plus4,                m_pc + 32'd4);
         check("cmp_fetch_req", {31'b0, fetch_req},      {31'b0, model_running()});
         check("cmp_redirect",  {31'b0, redirect},       {31'b0, model_redirect()});
         check("cmp_trap",      {31'b0, misalign_trap},  {31'b0, m_trapped});
         check("cmp_taken_cnt", {28'b0, taken_cnt},      m_cnt);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic apply(input logic bt, input logic j, input logic jr,
                        input logic [31:0] im, input logic [31:0] rs, input logic rdy);
      Btaken = bt; Jump = j; Jalr = jr; imm = im; rs1_data = rs; imem_ready = rdy;
      #2;
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reset asserted mid-cycle, held across one rising edge, released on a
   // falling edge.
   task automatic pulse_reset();
      #1 reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      #1 reset_n = 1'b0;
      @(negedge clk);
      check("rst_pc",   pc, 32'h0);
      check("rst_cnt",  {28'b0, taken_cnt}, 32'h0);
      check("rst_fetch", {31'b0, fetch_req}, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;

      // Reset release: one INIT cycle, then sequential fetch.
      apply(0, 0, 0, 0, 0, 1);
      check("init_pc",    pc, 32'h0);
      check("init_fetch", {31'b0, fetch_req}, 32'h0);
      tick();
      for (int k = 0; k < 4; k++) begin
         apply(0, 0, 0, 0, 0, 1);
         check("seq_pc",    pc, 32'(4 * k));
         check("seq_fetch", {31'b0, fetch_req}, 32'h1);
         tick();
      end
      // pc = 0x10 here. Jump back to 0 (1 redirect), then 14 more (count 15).
      apply(0, 1, 0, 32'hFFFF_FFF0, 0, 1); tick();
      for (int k = 0; k < 14; k++) begin
         apply(0, 1, 0, 32'h8, 0, 1); tick();
      end
      check("sat_pc_pre",  pc, 32'h70);
      check("sat_cnt_pre", {28'b0, taken_cnt}, 32'hF);
      apply(0, 1, 0, 32'h10, 0, 1);
      check("sat_redirect", {31'b0, redirect}, 32'h1);
      tick();
      check("sat_pc",  pc, 32'h80);
      check("sat_cnt", {28'b0, taken_cnt}, 32'hF);

      // Stall: Btaken held with imem_ready=0 for three cycles.
      for (int k = 0; k < 3; k++) begin
         apply(1, 0, 0, 32'h20, 0, 0);
         check("stall_pc",       pc, 32'h80);
         check("stall_redirect", {31'b0, redirect}, 32'h0);
         tick();
      end
      apply(1, 0, 0, 32'h20, 0, 1);
      check("stall_go_redirect", {31'b0, redirect}, 32'h1);
      tick();
      check("stall_go_pc", pc, 32'hA0);

      // Asynchronous reset between edges.
      apply(0, 0, 0, 0, 0, 1);
      #1 reset_n = 1'b0;
      #1;
      check("async_pc",    pc, 32'h0);
      check("async_cnt",   {28'b0, taken_cnt}, 32'h0);
      check("async_fetch", {31'b0, fetch_req}, 32'h0);
      check("async_redir", {31'b0, redirect}, 32'h0);
      tick();
      reset_n = 1'b1;

      // INIT, then 64 sequential steps to 0x100.
      apply(0, 0, 0, 0, 0, 1); tick();
      for (int k = 0; k < 64; k++) begin
         apply(0, 0, 0, 0, 0, 1); tick();
      end
      apply(1, 0, 0, 32'hFFFF_FFF0, 0, 1);
      check("br_back_pc_pre", pc, 32'h100);
      check("br_back_redirect", {31'b0, redirect}, 32'h1);
      tick();
      check("br_back_pc",  pc, 32'hF0);
      check("br_back_cnt", {28'b0, taken_cnt}, 32'h1);

      // To 0x200, then Jalr+Jump: Jalr wins, bit 0 cleared.
      apply(0, 1, 0, 32'h110, 0, 1); tick();
      apply(0, 1, 1, 32'h10, 32'h1001, 1);
      check("jalr_pc_pre", pc, 32'h200);
      tick();
      check("jalr_pc",  pc, 32'h1010);
      check("jalr_cnt", {28'b0, taken_cnt}, 32'h3);

      // Wrap: pc = 0xFFFFFFFC gives pc_plus4 = 0.
      apply(0, 1, 0, 32'hFFFF_EFEC, 0, 1); tick();
      apply(0, 0, 0, 0, 0, 1);
      check("wrap_pc",       pc, 32'hFFFF_FFFC);
      check("wrap_pc_plus4", pc_plus4, 32'h0);
      tick();
      check("wrap_next_pc", pc, 32'h0);

      // Misaligned jump at 0x40 -> TRAP.
      apply(0, 1, 0, 32'h40, 0, 1); tick();
      apply(0, 1, 0, 32'h6, 0, 1);
      check("mis_redirect", {31'b0, redirect}, 32'h0);
      tick();
      check("mis_pc",    pc, 32'h40);
      check("mis_trap",  {31'b0, misalign_trap}, 32'h1);
      check("mis_fetch", {31'b0, fetch_req}, 32'h0);
      check("mis_cnt",   {28'b0, taken_cnt}, 32'h5);
      for (int k = 0; k < 3; k++) begin
         apply(1, 1, 1, 32'h100, 32'h400, 1); tick();
      end
      check("trap_hold_pc",   pc, 32'h40);
      check("trap_hold_cnt",  {28'b0, taken_cnt}, 32'h5);
      check("trap_hold_flag", {31'b0, misalign_trap}, 32'h1);
      apply(0, 0, 0, 0, 0, 1);
      #1 reset_n = 1'b0;
      #1;
      check("trap_rst_pc",   pc, 32'h0);
      check("trap_rst_flag", {31'b0, misalign_trap}, 32'h0);
      tick();
      reset_n = 1'b1;

      // Randomized run against the model.
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] r_imm, r_rs;
         r_imm = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
         if ($urandom_range(0, 3) == 0) r_imm = -r_imm;
         r_rs  = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'h0000_3FFC);
         apply($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
               $urandom_range(0, 7) == 0, r_imm, r_rs, $urandom_range(0, 3) != 0);
         if ((m_trapped && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0)
            pulse_reset();
         else
            tick();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
